// File: rtl/accel_sample_filter.sv
// ---------------------------------------------------------------------------
// accel_sample_filter
//
// Conditions raw accelerometer X/Y readings before tilt thresholding. A free
// running divider produces one sample tick every SAMPLE_DIV clocks; on each
// tick both axes are captured, pushed through a 2^AVG_LOG2-tap moving average,
// and corrected by a per-axis level offset with saturation to the signed
// DATA_W range. A small calibration FSM averages 2^CAL_LOG2 filtered samples
// on request and installs the result as the new zero offset.
//
// Pipeline per tick (tick seen on clock edge T):
//   T    inputs captured
//   T+1  running sum updated, oldest tap replaced
//   T+2  average, offset subtraction, saturation, outputs + out_valid
//
// Optional feature (compile-time macro ACCEL_FILTER_DEADZONE_EN):
//   when defined, any corrected output with magnitude below DEADZONE is
//   forced to 0. Calibration always works on the uncorrected average.
//
// Ports:
//   clk          in   1       system clock
//   reset        in   1       asynchronous, active-high reset
//   accel_x_in   in   DATA_W  raw X reading, signed
//   accel_y_in   in   DATA_W  raw Y reading, signed
//   cal_req      in   1       1-cycle pulse: capture current level as zero
//   accel_x_out  out  DATA_W  filtered, offset-corrected X, signed
//   accel_y_out  out  DATA_W  filtered, offset-corrected Y, signed
//   out_valid    out  1       1-cycle pulse when outputs update
//   cal_busy     out  1       high while calibration accumulates
//   cal_done     out  1       1-cycle pulse when the new offset is applied
// ---------------------------------------------------------------------------
module accel_sample_filter #(
  parameter int DATA_W     = 9,
  parameter int SAMPLE_DIV = 1000000,
  parameter int AVG_LOG2   = 3,
  parameter int CAL_LOG2   = 4
`ifdef ACCEL_FILTER_DEADZONE_EN
  ,
  parameter int DEADZONE   = 4
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] accel_x_in,
  input  logic signed [DATA_W-1:0] accel_y_in,
  input  logic                     cal_req,
  output logic signed [DATA_W-1:0] accel_x_out,
  output logic signed [DATA_W-1:0] accel_y_out,
  output logic                     out_valid,
  output logic                     cal_busy,
  output logic                     cal_done
);

  localparam int TAPS  = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int ACC_W = DATA_W + CAL_LOG2;
  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  // Saturation bounds, both in the widened subtraction width and in the
  // output width.
  localparam logic signed [DATA_W:0]   SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0]   SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAL_ACC   = 2'd1,
    CAL_APPLY = 2'd2
  } cal_state_t;

  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;

  logic signed [DATA_W-1:0] raw_in  [2];
  logic signed [DATA_W-1:0] cap     [2];
  logic                     cap_valid;

  logic signed [DATA_W-1:0] taps    [2][TAPS];
  logic [AVG_LOG2-1:0]      tap_ptr;
  logic signed [SUM_W-1:0]  sum     [2];
  logic                     sum_valid;

  logic signed [DATA_W-1:0] avg     [2];
  logic signed [DATA_W:0]   diff    [2];
  logic signed [DATA_W-1:0] shaped  [2];

  logic signed [DATA_W-1:0] offset  [2];
  logic signed [ACC_W-1:0]  cal_acc [2];
  logic [CAL_LOG2-1:0]      cal_cnt;

  cal_state_t               state_q;
  cal_state_t               state_d;
  logic                     cal_start;
  logic                     acc_add;
  logic                     offset_load;

  // Sample-rate divider: counts 0..SAMPLE_DIV-1 and fires on terminal count.
  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Both axes share one datapath description, indexed 0 = X, 1 = Y.
  always_comb begin
    raw_in[0] = accel_x_in;
    raw_in[1] = accel_y_in;
  end

  // Stage 1: grab the controller's held readings on the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_valid <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        cap[a] <= '0;
      end
    end else begin
      cap_valid <= tick;
      if (tick) begin
        for (int a = 0; a < 2; a++) begin
          cap[a] <= raw_in[a];
        end
      end
    end
  end

  // Stage 2: running-sum moving average. The sum tracks the tap contents, so
  // adding the new sample and removing the one it overwrites keeps it exact.
  // Taps start at zero, which gives the warm-up ramp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_valid <= 1'b0;
      tap_ptr   <= '0;
      for (int a = 0; a < 2; a++) begin
        sum[a] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          taps[a][t] <= '0;
        end
      end
    end else begin
      sum_valid <= cap_valid;
      if (cap_valid) begin
        tap_ptr <= tap_ptr + 1'b1;
        for (int a = 0; a < 2; a++) begin
          sum[a]           <= sum[a] + SUM_W'(cap[a]) - SUM_W'(taps[a][tap_ptr]);
          taps[a][tap_ptr] <= cap[a];
        end
      end
    end
  end

  // Stage 3 (combinational part): floor average via the top bits of the
  // signed sum, one-bit-wider offset subtraction so it cannot wrap, then
  // clamp back into the output range.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      avg[a]  = sum[a][SUM_W-1:AVG_LOG2];
      diff[a] = {avg[a][DATA_W-1], avg[a]} - {offset[a][DATA_W-1], offset[a]};
      if (diff[a] > SAT_MAX) begin
        shaped[a] = OUT_MAX;
      end else if (diff[a] < SAT_MIN) begin
        shaped[a] = OUT_MIN;
      end else begin
        shaped[a] = diff[a][DATA_W-1:0];
      end
`ifdef ACCEL_FILTER_DEADZONE_EN
      if ((int'(shaped[a]) < DEADZONE) && (int'(shaped[a]) > -DEADZONE)) begin
        shaped[a] = '0;
      end
`endif
    end
  end

  // Stage 3 (registered part): outputs only change on a completed sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      accel_x_out <= '0;
      accel_y_out <= '0;
    end else begin
      out_valid <= sum_valid;
      if (sum_valid) begin
        accel_x_out <= shaped[0];
        accel_y_out <= shaped[1];
      end
    end
  end

  // Calibration FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Calibration FSM next state and controls. Averages are accumulated on the
  // same edge they are registered to the outputs; the offset is installed one
  // cycle later so the sample that completes calibration still uses the old
  // offset. Requests outside IDLE are ignored.
  always_comb begin
    state_d     = state_q;
    cal_busy    = 1'b0;
    cal_done    = 1'b0;
    cal_start   = 1'b0;
    acc_add     = 1'b0;
    offset_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (cal_req) begin
          cal_start = 1'b1;
          state_d   = CAL_ACC;
        end
      end
      CAL_ACC: begin
        cal_busy = 1'b1;
        if (sum_valid) begin
          acc_add = 1'b1;
          if (cal_cnt == '1) begin
            state_d = CAL_APPLY;
          end
        end
      end
      CAL_APPLY: begin
        cal_done    = 1'b1;
        offset_load = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Calibration accumulators and the live offsets. The offset is the floor
  // of the accumulated averages divided by the sample count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_cnt <= '0;
      for (int a = 0; a < 2; a++) begin
        cal_acc[a] <= '0;
        offset[a]  <= '0;
      end
    end else begin
      if (cal_start) begin
        cal_cnt <= '0;
        for (int a = 0; a < 2; a++) begin
          cal_acc[a] <= '0;
        end
      end else if (acc_add) begin
        cal_cnt <= cal_cnt + 1'b1;
        for (int a = 0; a < 2; a++) begin
          cal_acc[a] <= cal_acc[a] + ACC_W'(avg[a]);
        end
      end
      if (offset_load) begin
        for (int a = 0; a < 2; a++) begin
          offset[a] <= cal_acc[a][ACC_W-1:CAL_LOG2];
        end
      end
    end
  end

endmodule

// File: tb/tb_accel_sample_filter.sv
// ---------------------------------------------------------------------------
// tb_accel_sample_filter
//
// Drives accel_sample_filter with directed scenarios and a randomized phase,
// predicting every output sample from a behavioural model that keeps the
// last 2^AVG_LOG2 raw samples in a queue, averages them with floor division
// and tracks calibration as a simple running total.
// ---------------------------------------------------------------------------
module tb_accel_sample_filter;

  localparam int DATA_W     = 9;
  localparam int SAMPLE_DIV = 4;
  localparam int AVG_LOG2   = 3;
  localparam int CAL_LOG2   = 4;
  localparam int TAPS       = 1 << AVG_LOG2;
  localparam int CAL_N      = 1 << CAL_LOG2;
  localparam int OUT_HI     = (1 << (DATA_W - 1)) - 1;
  localparam int OUT_LO     = -(1 << (DATA_W - 1));
`ifdef ACCEL_FILTER_DEADZONE_EN
  localparam int DEADZONE   = 4;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] accel_x_in;
  logic signed [DATA_W-1:0] accel_y_in;
  logic                     cal_req;
  logic signed [DATA_W-1:0] accel_x_out;
  logic signed [DATA_W-1:0] accel_y_out;
  logic                     out_valid;
  logic                     cal_busy;
  logic                     cal_done;

  // Comparison bookkeeping and cycle tracking.
  int vectors        = 0;
  int miscompares    = 0;
  int cyc            = 0;
  int last_valid_cyc = 0;
  bit last_done      = 1'b0;

  // Behavioural model state.
  int hist_x[$];
  int hist_y[$];
  int off_x;
  int off_y;
  bit cal_on;
  int cal_n;
  int acc_x;
  int acc_y;

  accel_sample_filter #(
    .DATA_W     (DATA_W),
    .SAMPLE_DIV (SAMPLE_DIV),
    .AVG_LOG2   (AVG_LOG2),
    .CAL_LOG2   (CAL_LOG2)
`ifdef ACCEL_FILTER_DEADZONE_EN
    ,
    .DEADZONE   (DEADZONE)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .accel_x_in  (accel_x_in),
    .accel_y_in  (accel_y_in),
    .cal_req     (cal_req),
    .accel_x_out (accel_x_out),
    .accel_y_out (accel_y_out),
    .out_valid   (out_valid),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done)
  );

  // 100 MHz clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single point of comparison: counts, and reports any difference.
  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled.
  task automatic step_neg();
    @(negedge clk);
    cyc++;
  endtask

  // Floor division for a positive divisor.
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int clamp_out(input int v);
    if (v > OUT_HI) return OUT_HI;
    if (v < OUT_LO) return OUT_LO;
    return v;
  endfunction

  function automatic int shape(input int v);
    int r;
    r = clamp_out(v);
`ifdef ACCEL_FILTER_DEADZONE_EN
    if ((r < DEADZONE) && (r > -DEADZONE)) r = 0;
`endif
    return r;
  endfunction

  function automatic int window_avg(input int q[$]);
    int s;
    s = 0;
    foreach (q[i]) s += q[i];
    return floor_div(s, TAPS);
  endfunction

  function automatic int rand_sample();
    case ($urandom_range(0, 7))
      0:       return OUT_LO;
      1:       return OUT_HI;
      default: return int'($urandom_range(0, 511)) - 256;
    endcase
  endfunction

  // Model reset: empty history (all-zero taps), zero offsets, no calibration.
  task automatic model_reset();
    hist_x.delete();
    hist_y.delete();
    for (int i = 0; i < TAPS; i++) begin
      hist_x.push_back(0);
      hist_y.push_back(0);
    end
    off_x  = 0;
    off_y  = 0;
    cal_on = 1'b0;
    cal_n  = 0;
    acc_x  = 0;
    acc_y  = 0;
  endtask

  // A calibration request only starts a new run when none is in progress.
  task automatic model_cal_req();
    if (!cal_on) begin
      cal_on = 1'b1;
      cal_n  = 0;
      acc_x  = 0;
      acc_y  = 0;
    end
  endtask

  // Predict one output sample from one input sample.
  task automatic model_sample(input int x, input int y,
                              output int ex, output int ey,
                              output int ebusy, output int edone);
    int ax;
    int ay;
    hist_x.push_back(x);
    void'(hist_x.pop_front());
    hist_y.push_back(y);
    void'(hist_y.pop_front());
    ax    = window_avg(hist_x);
    ay    = window_avg(hist_y);
    ex    = shape(ax - off_x);
    ey    = shape(ay - off_y);
    edone = 0;
    if (cal_on) begin
      acc_x += ax;
      acc_y += ay;
      cal_n++;
      if (cal_n == CAL_N) begin
        off_x  = floor_div(acc_x, CAL_N);
        off_y  = floor_div(acc_y, CAL_N);
        cal_on = 1'b0;
        edone  = 1;
      end
    end
    ebusy = cal_on ? 1 : 0;
  endtask

  // Wait (bounded) for the next out_valid and check the spacing from the last.
  task automatic wait_valid(input int exp_gap);
    bit seen;
    seen = 1'b0;
    for (int i = 0; (i < 24) && !seen; i++) begin
      step_neg();
      if (out_valid) seen = 1'b1;
      else checkOutput("cal_done_without_valid", int'(cal_done), 0);
    end
    if (!seen) checkOutput("valid_timeout", 0, 1);
    else checkOutput("valid_spacing", cyc - last_valid_cyc, exp_gap);
    last_valid_cyc = cyc;
  endtask

  task automatic check_sample(input int x, input int y);
    int ex;
    int ey;
    int eb;
    int ed;
    model_sample(x, y, ex, ey, eb, ed);
    checkOutput("x_out", int'(accel_x_out), ex);
    checkOutput("y_out", int'(accel_y_out), ey);
    checkOutput("cal_busy", int'(cal_busy), eb);
    checkOutput("cal_done", int'(cal_done), ed);
    last_done = (ed != 0);
  endtask

  // Present one sample (called on the falling edge where the previous
  // out_valid was seen), optionally with a cal_req pulse that lands either
  // before or exactly on the next tick edge.
  task automatic applyStimulus(input int x, input int y, input bit req);
    bit dly;
    accel_x_in = DATA_W'(x);
    accel_y_in = DATA_W'(y);
    if (req) begin
      dly = last_done ? 1'b1 : 1'($urandom_range(0, 1));
      if (dly) step_neg();
      cal_req = 1'b1;
      step_neg();
      cal_req = 1'b0;
      model_cal_req();
    end
    wait_valid(SAMPLE_DIV);
    check_sample(x, y);
  endtask

  task automatic run_samples(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) applyStimulus(x, y, 1'b0);
  endtask

  // Assert reset (possibly mid-cycle), check the immediate effect, release on
  // a falling edge and check the first sample and its latency.
  task automatic apply_reset(input int x, input int y);
    reset      = 1'b1;
    cal_req    = 1'b0;
    accel_x_in = DATA_W'(x);
    accel_y_in = DATA_W'(y);
    #1;
    checkOutput("rst_x_out", int'(accel_x_out), 0);
    checkOutput("rst_y_out", int'(accel_y_out), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_cal_busy", int'(cal_busy), 0);
    checkOutput("rst_cal_done", int'(cal_done), 0);
    step_neg();
    step_neg();
    checkOutput("rst_held_valid", int'(out_valid), 0);
    checkOutput("rst_held_x_out", int'(accel_x_out), 0);
    model_reset();
    last_done      = 1'b0;
    reset          = 1'b0;
    last_valid_cyc = cyc;
    wait_valid(SAMPLE_DIV + 2);
    check_sample(x, y);
  endtask

  initial begin
    int rx;
    int ry;
    reset      = 1'b0;
    cal_req    = 1'b0;
    accel_x_in = '0;
    accel_y_in = '0;
    #2;

    // Reset behaviour, warm-up ramp and settling on a constant input.
    $display("[TB] reset and warm-up");
    apply_reset(40, -24);
    run_samples(40, -24, 10);

    // Step from settled 40 down to 0 on X.
    $display("[TB] step response");
    run_samples(0, -24, 10);

    // Calibration at a settled level, with an extra request while busy.
    $display("[TB] calibration");
    run_samples(16, -8, 10);
    applyStimulus(16, -8, 1'b1);
    for (int i = 1; i < CAL_N; i++) applyStimulus(16, -8, i == 5);
    applyStimulus(16, -8, 1'b0);
    run_samples(26, -8, 10);

    // Saturation at both ends of the output range.
    $display("[TB] saturation");
    run_samples(-200, -200, 10);
    applyStimulus(-200, -200, 1'b1);
    run_samples(-200, -200, CAL_N);
    run_samples(255, 255, 10);
    run_samples(200, 200, 10);
    applyStimulus(200, 200, 1'b1);
    run_samples(200, 200, CAL_N);
    run_samples(-256, -256, 10);

    // Asynchronous reset in the middle of a calibration run.
    $display("[TB] reset during calibration");
    run_samples(16, 16, 10);
    applyStimulus(16, 16, 1'b1);
    run_samples(16, 16, 5);
    accel_x_in = DATA_W'(16);
    accel_y_in = DATA_W'(16);
    step_neg();
    step_neg();
    #2;
    checkOutput("busy_before_reset", int'(cal_busy), 1);
    apply_reset(16, 16);
    run_samples(16, 16, 9);

    // Small magnitudes around the deadzone threshold.
    $display("[TB] small levels");
    run_samples(3, -3, 10);
    run_samples(4, 4, 10);
    run_samples(-3, 3, 10);

    // Randomized phase: held levels, random jumps and calibration requests.
    $display("[TB] random phase");
    rx = 0;
    ry = 0;
    for (int i = 0; i < 220; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rx = rand_sample();
        ry = rand_sample();
      end
      applyStimulus(rx, ry, $urandom_range(0, 11) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
